// File: rtl/opb_mst_pkg.sv
// Shared types for the OPB register master: request record, FSM states, widths.
// Build option: OPB_MST_READBACK_EN adds the write-verify (VFY) state.
package opb_mst_pkg;

    localparam int OPB_AW = 32;
    localparam int OPB_DW = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              wr;
        logic [OPB_AW-1:0] addr;
        logic [OPB_DW-1:0] wdata;
    } opb_req_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
`ifdef OPB_MST_READBACK_EN
        S_VFY  = 3'd5,
`endif
        S_RSP  = 3'd3,
        S_GAP  = 3'd4
    } opb_state_t;

endpackage

// File: rtl/opb_req_fifo.sv
// Request FIFO for the OPB master; head is the incoming request when empty,
// so an idle master can issue a push in the same cycle it is accepted.
module opb_req_fifo
    import opb_mst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     OPB_CLK,
    input  logic     OPB_RST,
    input  logic     push,
    input  opb_req_t din,
    input  logic     pop,
    output opb_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    opb_req_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign dout  = empty ? din : mem[rd_ptr];
    assign do_rd = pop && !empty;
    assign do_wr = push && !full && !(pop && empty);

    // Pointer and occupancy bookkeeping; reset flushes the queue
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_wr && !do_rd)
                count <= count + CNT_ONE;
            else if (!do_wr && do_rd)
                count <= count - CNT_ONE;
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge OPB_CLK) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/opb_reg_master.sv
// OPB initiator: queued register requests become single-beat RE/WE strobes.
// Build option: OPB_MST_READBACK_EN re-reads each write and flags mismatches.
module opb_reg_master
    import opb_mst_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          RD_LAT      = 1,
    parameter int          IDLE_GAP    = 1,
    parameter logic [31:0] VERIFY_MASK = 32'h0000FFFF
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic        RSP_WR,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        BUSY,
    output logic [31:0] OPB_ADDR,
    output logic [31:0] OPB_WDATA,
    output logic        OPB_RE,
    output logic        OPB_WE,
    input  logic [31:0] OPB_RDATA
);

    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    opb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    opb_req_t         req_in, head;
    logic             push, pop, full, empty, avail;
    logic             re_d, we_d, rsp_valid_d, rsp_wr_d;
    logic [31:0]      addr_d, wdata_d, rsp_rdata_d;
`ifdef OPB_MST_READBACK_EN
    logic [31:0]      wd_q, wd_d;
    logic             rsp_err_d;
`endif

    assign req_in    = '{wr: REQ_WR, addr: REQ_ADDR, wdata: REQ_WDATA};
    assign push      = REQ_VALID && !full;
    assign avail     = !empty || push;
    assign REQ_READY = !full;
    assign BUSY      = !empty || (state_q != S_IDLE);

    opb_req_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .OPB_CLK(OPB_CLK),
        .OPB_RST(OPB_RST),
        .push   (push),
        .din    (req_in),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    // Next state, latency counter and next registered OPB/response values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        re_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_wr_d    = 1'b0;
        rsp_rdata_d = '0;
`ifdef OPB_MST_READBACK_EN
        wd_d        = wd_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (avail) begin
                    pop    = 1'b1;
                    addr_d = head.addr;
                    if (head.wr) begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        wdata_d = head.wdata;
`ifdef OPB_MST_READBACK_EN
                        wd_d    = head.wdata;
`endif
                    end else begin
                        state_d = S_RD;
                        re_d    = 1'b1;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WR: begin
`ifdef OPB_MST_READBACK_EN
                state_d = S_VFY;
                re_d    = 1'b1;
                addr_d  = OPB_ADDR;
                cnt_d   = LAT_M1;
`else
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_wr_d    = 1'b1;
`endif
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = OPB_RDATA;
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    re_d   = 1'b1;
                    addr_d = OPB_ADDR;
                end
            end
`ifdef OPB_MST_READBACK_EN
            S_VFY: begin
                if (cnt_q == '0) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = 1'b1;
                    rsp_rdata_d = OPB_RDATA;
                    rsp_err_d   = |((OPB_RDATA ^ wd_q) & VERIFY_MASK);
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    re_d   = 1'b1;
                    addr_d = OPB_ADDR;
                end
            end
`endif
            S_RSP: begin
                if (IDLE_GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_M1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and latency counter
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered OPB strobes and response pulse
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            OPB_RE    <= 1'b0;
            OPB_WE    <= 1'b0;
            OPB_ADDR  <= '0;
            OPB_WDATA <= '0;
            RSP_VALID <= 1'b0;
            RSP_WR    <= 1'b0;
            RSP_RDATA <= '0;
        end else begin
            OPB_RE    <= re_d;
            OPB_WE    <= we_d;
            OPB_ADDR  <= addr_d;
            OPB_WDATA <= wdata_d;
            RSP_VALID <= rsp_valid_d;
            RSP_WR    <= rsp_wr_d;
            RSP_RDATA <= rsp_rdata_d;
        end
    end

`ifdef OPB_MST_READBACK_EN
    // Write data kept for the readback compare, plus the error flag
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            wd_q    <= '0;
            RSP_ERR <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            RSP_ERR <= rsp_err_d;
        end
    end
`else
    assign RSP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_opb_reg_master.sv
// Bench for opb_reg_master: directed vector table, burst, reset abort and
// randomized traffic against a transaction-level reference model.
module tb_opb_reg_master;

    localparam int          FIFO_DEPTH = 4;
    localparam int          RD_LAT     = 2;
    localparam int          IDLE_GAP   = 1;
    localparam logic [31:0] MASK       = 32'h0000FFFF;
`ifdef OPB_MST_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WR = 1'b0;
    logic [31:0] REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic        RSP_VALID, RSP_WR, RSP_ERR, BUSY;
    logic [31:0] RSP_RDATA, OPB_ADDR, OPB_WDATA, OPB_RDATA;
    logic        OPB_RE, OPB_WE;

    bit          fixed = 1'b1;
    logic [31:0] fixed_val = '0;

    int total = 0;
    int bad = 0;

    always #5 OPB_CLK = ~OPB_CLK;

    function automatic logic [31:0] slv_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign OPB_RDATA = OPB_RE ? (fixed ? fixed_val : slv_fn(OPB_ADDR)) : 32'h0;

    opb_reg_master #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LAT     (RD_LAT),
        .IDLE_GAP   (IDLE_GAP),
        .VERIFY_MASK(MASK)
    ) dut (
        .OPB_CLK  (OPB_CLK),
        .OPB_RST  (OPB_RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WR   (REQ_WR),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_WR   (RSP_WR),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR  (RSP_ERR),
        .BUSY     (BUSY),
        .OPB_ADDR (OPB_ADDR),
        .OPB_WDATA(OPB_WDATA),
        .OPB_RE   (OPB_RE),
        .OPB_WE   (OPB_WE),
        .OPB_RDATA(OPB_RDATA)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  re_len;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    obs_t obs_q[$];
    rsp_t rsp_q[$];

    // Bus monitor: collects transactions/responses, counts protocol violations
    int   cyc = 0;
    int   last_rsp = -1000;
    bit   in_txn = 1'b0;
    bit   pend = 1'b0;
    obs_t cur;
    int   excl_viol = 0;
    int   stable_viol = 0;
    int   zero_viol = 0;
    int   outst_viol = 0;
    int   gap_viol = 0;

    always @(negedge OPB_CLK) begin
        cyc <= cyc + 1;
        if (OPB_RST) begin
            in_txn <= 1'b0;
            pend   <= 1'b0;
        end else begin
            if (OPB_RE && OPB_WE) excl_viol <= excl_viol + 1;
            if (OPB_RE || OPB_WE) begin
                if (!in_txn) begin
                    if (pend) outst_viol <= outst_viol + 1;
                    if (cyc - last_rsp < IDLE_GAP + 1) gap_viol <= gap_viol + 1;
                    cur    <= '{wr: OPB_WE, addr: OPB_ADDR, wdata: OPB_WDATA,
                                re_len: OPB_RE ? 8'd1 : 8'd0};
                    in_txn <= 1'b1;
                    pend   <= 1'b1;
                end else begin
                    if (OPB_ADDR != cur.addr) stable_viol <= stable_viol + 1;
                    if (OPB_RE) cur.re_len <= cur.re_len + 8'd1;
                end
            end else begin
                if (OPB_ADDR != 32'h0 || OPB_WDATA != 32'h0)
                    zero_viol <= zero_viol + 1;
                if (in_txn) begin
                    obs_q.push_back(cur);
                    in_txn <= 1'b0;
                end
            end
            if (RSP_VALID) begin
                rsp_q.push_back('{wr: RSP_WR, rdata: RSP_RDATA, err: RSP_ERR});
                last_rsp <= cyc;
                pend     <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge OPB_CLK); #1;
            n++;
        end while ((BUSY || in_txn) && n < 300);
        chk("drain_busy", BUSY, 0);
        repeat (2) @(posedge OPB_CLK);
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slave;
        int          exp_we;
        int          exp_re;
        int          exp_rsp;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[6];

    // One isolated request; cycle offsets are relative to the accept cycle
    task automatic run_single(input int idx, input vec_t v);
        int first = 0, we_n = 0, re_n = 0, rsp_k = -1;
        bit addr_ok = 1'b1, wd_ok = 1'b1;
        logic rw = 1'b0, rerr = 1'b0;
        logic [31:0] rd = '0;
        fixed_val = v.slave;
        REQ_VALID = 1'b1;
        REQ_WR    = v.wr;
        REQ_ADDR  = v.addr;
        REQ_WDATA = v.wdata;
        chk($sformatf("v%0d_ready", idx), REQ_READY, 1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge OPB_CLK); #1;
            if (k == 1) REQ_VALID = 1'b0;
            if ((OPB_RE || OPB_WE) && first == 0) first = k;
            if (OPB_WE) begin
                we_n++;
                if (OPB_WDATA != v.wdata) wd_ok = 1'b0;
            end
            if (OPB_RE) re_n++;
            if ((OPB_RE || OPB_WE) && OPB_ADDR != v.addr) addr_ok = 1'b0;
            if (RSP_VALID && rsp_k < 0) begin
                rsp_k = k;
                rw    = RSP_WR;
                rd    = RSP_RDATA;
                rerr  = RSP_ERR;
            end
        end
        chk($sformatf("v%0d_first_strobe", idx), first, 1);
        chk($sformatf("v%0d_we_cycles", idx), we_n, v.exp_we);
        chk($sformatf("v%0d_re_cycles", idx), re_n, v.exp_re);
        chk($sformatf("v%0d_addr", idx), addr_ok, 1);
        chk($sformatf("v%0d_wdata", idx), wd_ok, 1);
        chk($sformatf("v%0d_rsp_cycle", idx), rsp_k, v.exp_rsp);
        chk($sformatf("v%0d_rsp_wr", idx), rw, v.wr);
        chk($sformatf("v%0d_rsp_rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d_rsp_err", idx), rerr, v.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int   ob, rb, i, n, acc, cnt_re, cnt_rsp;
        bit   saw_full, have, drv;
        req_t cur_req;
        req_t exp_q[$];

        vt[0] = '{1'b1, 32'h1, 32'hFA, 32'h0, 1, RB ? RD_LAT : 0,
                  RB ? RD_LAT + 2 : 2, 32'h0, RB};
        vt[1] = '{1'b0, 32'h6, 32'h0, 32'h3E8, 0, RD_LAT, RD_LAT + 1, 32'h3E8, 1'b0};
        vt[2] = '{1'b1, 32'h1, 32'hFA, 32'hFFFF00FA, 1, RB ? RD_LAT : 0,
                  RB ? RD_LAT + 2 : 2, RB ? 32'hFFFF00FA : 32'h0, 1'b0};
        vt[3] = '{1'b0, 32'hFFFFFFFC, 32'h0, 32'hDEADBEEF, 0, RD_LAT, RD_LAT + 1,
                  32'hDEADBEEF, 1'b0};
        vt[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 1, RB ? RD_LAT : 0,
                  RB ? RD_LAT + 2 : 2, RB ? 32'h0000FFFF : 32'h0, 1'b0};
        vt[5] = '{1'b1, 32'h10, 32'h1234, 32'h1235, 1, RB ? RD_LAT : 0,
                  RB ? RD_LAT + 2 : 2, RB ? 32'h1235 : 32'h0, RB};

        repeat (3) @(posedge OPB_CLK);
        #1;
        chk("rst_ready", REQ_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_re", OPB_RE, 0);
        chk("rst_we", OPB_WE, 0);
        chk("rst_addr", OPB_ADDR, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_rdata", RSP_RDATA, 0);
        OPB_RST = 1'b0;
        @(posedge OPB_CLK); #1;

        foreach (vt[k]) run_single(k, vt[k]);

        // Burst of eight writes against a four-deep queue
        fixed = 1'b0;
        ob = obs_q.size();
        rb = rsp_q.size();
        i = 0;
        n = 0;
        saw_full = 1'b0;
        while (i < 8 && n < 500) begin
            REQ_VALID = 1'b1;
            REQ_WR    = 1'b1;
            REQ_ADDR  = i + 1;
            REQ_WDATA = 32'h100 + i;
            if (!REQ_READY) saw_full = 1'b1;
            drv = REQ_READY;
            @(posedge OPB_CLK); #1;
            n++;
            if (drv) i++;
        end
        REQ_VALID = 1'b0;
        chk("burst_accepted", i, 8);
        chk("burst_saw_full", saw_full, 1);
        wait_idle();
        chk("burst_obs_n", obs_q.size() - ob, 8);
        chk("burst_rsp_n", rsp_q.size() - rb, 8);
        for (int k = 0; k < 8 && ob + k < obs_q.size(); k++) begin
            chk($sformatf("burst%0d_wr", k), obs_q[ob+k].wr, 1);
            chk($sformatf("burst%0d_addr", k), obs_q[ob+k].addr, k + 1);
            chk($sformatf("burst%0d_wdata", k), obs_q[ob+k].wdata, 32'h100 + k);
        end

        // Reset during the second RE cycle with more requests behind it
        fixed = 1'b1;
        fixed_val = 32'h55;
        rb = rsp_q.size();
        REQ_VALID = 1'b1;
        REQ_WR    = 1'b0;
        REQ_ADDR  = 32'h20;
        @(posedge OPB_CLK); #1;
        chk("abort_re1", OPB_RE, 1);
        REQ_WR    = 1'b1;
        REQ_ADDR  = 32'h24;
        REQ_WDATA = 32'h77;
        @(posedge OPB_CLK); #1;
        chk("abort_re2", OPB_RE, 1);
        REQ_ADDR = 32'h28;
        OPB_RST = 1'b1;
        #1;
        chk("abort_re_drop", OPB_RE, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_ready", REQ_READY, 1);
        @(posedge OPB_CLK); #1;
        REQ_VALID = 1'b0;
        OPB_RST = 1'b0;
        cnt_re = 0;
        cnt_rsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge OPB_CLK); #1;
            if (OPB_RE || OPB_WE || BUSY) cnt_re++;
            if (RSP_VALID) cnt_rsp++;
        end
        chk("abort_no_activity", cnt_re, 0);
        chk("abort_no_rsp", cnt_rsp, 0);
        chk("abort_rsp_q", rsp_q.size() - rb, 0);

        // Randomized traffic against the transaction model
        fixed = 1'b0;
        ob = obs_q.size();
        rb = rsp_q.size();
        acc = 0;
        have = 1'b0;
        drv = 1'b0;
        cur_req = '0;
        for (int c = 0; c < 4000 && acc < 40; c++) begin
            @(posedge OPB_CLK); #1;
            if (drv) begin
                exp_q.push_back(cur_req);
                acc++;
                have = 1'b0;
            end
            if (!have && acc < 40) begin
                cur_req.wr    = $urandom_range(0, 1);
                cur_req.addr  = $urandom;
                cur_req.wdata = $urandom;
                if ($urandom_range(0, 1) == 1)
                    cur_req.wdata = slv_fn(cur_req.addr) ^ ($urandom & ~MASK);
                have = 1'b1;
            end
            REQ_VALID = have && acc < 40 && ($urandom_range(0, 3) != 0);
            REQ_WR    = cur_req.wr;
            REQ_ADDR  = cur_req.addr;
            REQ_WDATA = cur_req.wdata;
            drv = REQ_VALID && REQ_READY;
        end
        REQ_VALID = 1'b0;
        chk("rand_accepted", acc, 40);
        wait_idle();
        chk("rand_obs_n", obs_q.size() - ob, exp_q.size());
        chk("rand_rsp_n", rsp_q.size() - rb, exp_q.size());
        foreach (exp_q[k]) begin
            req_t        r;
            logic [31:0] rdv;
            r = exp_q[k];
            rdv = slv_fn(r.addr);
            if (ob + k < obs_q.size()) begin
                chk($sformatf("rand%0d_kind", k), obs_q[ob+k].wr, r.wr);
                chk($sformatf("rand%0d_addr", k), obs_q[ob+k].addr, r.addr);
                chk($sformatf("rand%0d_wdata", k), obs_q[ob+k].wdata,
                    r.wr ? r.wdata : 32'h0);
                chk($sformatf("rand%0d_re_len", k), obs_q[ob+k].re_len,
                    r.wr ? (RB ? RD_LAT : 0) : RD_LAT);
            end
            if (rb + k < rsp_q.size()) begin
                chk($sformatf("rand%0d_rsp_wr", k), rsp_q[rb+k].wr, r.wr);
                chk($sformatf("rand%0d_rsp_rdata", k), rsp_q[rb+k].rdata,
                    (!r.wr || RB) ? rdv : 32'h0);
                chk($sformatf("rand%0d_rsp_err", k), rsp_q[rb+k].err,
                    RB && r.wr && (((rdv ^ r.wdata) & MASK) != 0));
            end
        end

        chk("mon_re_we_exclusive", excl_viol, 0);
        chk("mon_addr_stable", stable_viol, 0);
        chk("mon_idle_bus_zero", zero_viol, 0);
        chk("mon_one_outstanding", outst_viol, 0);
        chk("mon_idle_gap", gap_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
